// File: rtl/sub_bytes_hamming_pipe.sv
// Two-stage SubBytes pipeline with a Hamming(12,8) check on every lane's S-box output.
// A one-shot codeword corruption can be armed with an input beat to exercise the error path.
module sub_bytes_hamming_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_err,
  input  logic                 inj_en,
  input  logic [3:0]           inj_lane,
  input  logic [11:0]          inj_mask,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     err_count
);

  // valid/ready: a beat moves when valid & ready at the rising edge; a stage may load when it is
  // empty or the stage after it loads this cycle, so a stalled full pipeline holds everything.
  logic                   w_s1_en, w_s2_en;
  logic                   r_s1_valid, r_s2_valid;
  logic [LANES-1:0][7:0]  r_s1_data, r_s2_data, w_sbox, w_cw_data;
  logic [LANES-1:0][3:0]  w_pred, r_s1_chk, w_cw_chk, w_syn;
  logic [LANES-1:0]       w_inj_sel, r_s1_inj, w_syn_nz, r_s2_err;
  logic [11:0]            r_s1_mask;
  logic [CNT_W-1:0]       r_err_count;
  logic                   r_err_sticky;

  assign w_s2_en  = !r_s2_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    SubBytesHammingPredictor u_pred (.i_byte(in_data[8*l +: 8]), .o_chk(w_pred[l]));
    SubBytes u_sbox (.i_byte(r_s1_data[l]), .o_byte(w_sbox[l]));
    // An out-of-range inj_lane matches no lane, so it is ignored naturally.
    assign w_inj_sel[l] = inj_en && (inj_lane == 4'(l));
    assign w_cw_data[l] = w_sbox[l] ^ (r_s1_inj[l] ? r_s1_mask[11:4] : 8'h00);
    assign w_cw_chk[l]  = r_s1_chk[l] ^ (r_s1_inj[l] ? r_s1_mask[3:0] : 4'h0);
    SubBytesHammingChecker u_chk (
      .i_data    (w_cw_data[l]),
      .i_chk     (w_cw_chk[l]),
      .o_syndrome(w_syn[l])
    );
    assign w_syn_nz[l] = |w_syn[l];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_inj   <= '0;
      r_s2_err   <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= in_valid;
        r_s1_inj   <= in_valid ? w_inj_sel : '0;
      end
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        r_s2_err   <= r_s1_valid ? w_syn_nz : '0;
      end
    end
  end

  // Payload registers carry no reset; their contents only matter behind a valid bit.
  always_ff @(posedge clk) begin
    if (w_s1_en) begin
      r_s1_data <= in_data;
      r_s1_chk  <= w_pred;
      r_s1_mask <= inj_mask;
    end
    if (w_s2_en) begin
      r_s2_data <= w_cw_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (r_s2_valid && out_ready && |r_s2_err) begin
      r_err_sticky <= 1'b1;
      if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign out_err    = r_s2_err;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;

endmodule

module SubBytes (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign o_byte = SBOX[i_byte];
endmodule

// Check bits of the S-box output, derived from the input byte one stage ahead of the S-box.
// Data bits sit at Hamming positions 3,5,6,7,9,10,11,12; check bits at 1,2,4,8.
module SubBytesHammingPredictor (
  input  logic [7:0] i_byte,
  output logic [3:0] o_chk
);
  logic [7:0] w_s;
  SubBytes u_sbox (.i_byte(i_byte), .o_byte(w_s));
  assign o_chk = {w_s[4] ^ w_s[5] ^ w_s[6] ^ w_s[7],
                  w_s[1] ^ w_s[2] ^ w_s[3] ^ w_s[7],
                  w_s[0] ^ w_s[2] ^ w_s[3] ^ w_s[5] ^ w_s[6],
                  w_s[0] ^ w_s[1] ^ w_s[3] ^ w_s[4] ^ w_s[6]};
endmodule

// Every codeword column is a distinct nonzero syndrome, so any 1- or 2-bit flip reads nonzero.
module SubBytesHammingChecker (
  input  logic [7:0] i_data,
  input  logic [3:0] i_chk,
  output logic [3:0] o_syndrome
);
  assign o_syndrome = i_chk ^ {i_data[4] ^ i_data[5] ^ i_data[6] ^ i_data[7],
                               i_data[1] ^ i_data[2] ^ i_data[3] ^ i_data[7],
                               i_data[0] ^ i_data[2] ^ i_data[3] ^ i_data[5] ^ i_data[6],
                               i_data[0] ^ i_data[1] ^ i_data[3] ^ i_data[4] ^ i_data[6]};
endmodule

// File: tb/tb_sub_bytes_hamming_pipe.sv
// Directed bench for sub_bytes_hamming_pipe: S-box reference built from GF(2^8) arithmetic,
// expected-queue scoreboard on the output handshake, second instance with a 2-bit counter.
module tb_sub_bytes_hamming_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, inj_en, err_clr;
  logic [31:0] in_data;
  logic [3:0]  inj_lane;
  logic [11:0] inj_mask;
  logic        in_ready, out_valid, err_sticky;
  logic [31:0] out_data;
  logic [3:0]  out_err;
  logic [7:0]  err_count;
  logic        c2_in_ready, c2_out_valid, c2_err_sticky;
  logic [31:0] c2_out_data;
  logic [3:0]  c2_out_err;
  logic [1:0]  c2_err_count;

  always #5 clk = ~clk;

  sub_bytes_hamming_pipe #(.LANES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask), .err_clr(err_clr),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  sub_bytes_hamming_pipe #(.LANES(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready), .in_data(in_data),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data), .out_err(c2_out_err),
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask), .err_clr(err_clr),
    .err_sticky(c2_err_sticky), .err_count(c2_err_count)
  );

  logic [7:0]  sbox_ref [256];
  logic [35:0] exp_q [$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_out = 0, last_out_cyc = 0, mark_n = -1, mark_cyc = 0, acc_cyc = 0, n_acc = 0;
  logic [31:0] last_out_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox_ref();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_ref[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // Expected {out_err, out_data}; masks used here have 1 or 2 bits, so a hit lane always flags.
  function automatic logic [35:0] exp_word(input logic [31:0] d, input logic inj,
                                           input logic [3:0] lane, input logic [11:0] mask);
    logic [31:0] o;
    logic [3:0]  e;
    for (int l = 0; l < 4; l++) begin
      o[8*l +: 8] = sbox_ref[d[8*l +: 8]];
      e[l] = 1'b0;
      if (inj && lane == 4'(l)) begin
        o[8*l +: 8] = o[8*l +: 8] ^ mask[11:4];
        e[l] = (mask != 12'h000);
      end
    end
    return {e, o};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic inj, input logic [3:0] lane,
                           input logic [11:0] mask);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; inj_en = inj; inj_lane = lane; inj_mask = mask;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      exp_q.push_back(exp_word(d, inj, lane, mask));
      n_acc++;
    end else check("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
    inj_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  // Scoreboard on every output handshake.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_err", out_err, e[35:32]);
          check("c2_out_data", c2_out_data, e[31:0]);
          check("c2_out_err", c2_out_err, e[35:32]);
        end
        if (n_out == mark_n) mark_cyc = cyc;
        n_out++;
        last_out_cyc = cyc;
        last_out_data = out_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] held;
    build_sbox_ref();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    inj_en = 1'b0; inj_lane = '0; inj_mask = '0; err_clr = 1'b0;
    idle(3);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_err_count", err_count, 8'd0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_out_err", out_err, 4'h0);
    rst_n = 1'b1;
    idle(1);

    // Single beat: value and latency.
    send_beat(32'h5300_0001, 1'b0, 4'd0, 12'h000);
    drain();
    check("basic_data", last_out_data, 32'hED63_637C);
    check("basic_latency", last_out_cyc - acc_cyc, 2);
    check("basic_err_count", err_count, 8'd0);

    // Back-to-back sweep of every byte value on every lane.
    mark_n = n_out;
    n0 = n_out;
    for (int k = 0; k < 256; k++)
      send_beat({8'(k + 192), 8'(k + 128), 8'(k + 64), 8'(k)}, 1'b0, 4'd0, 12'h000);
    drain();
    check("sweep_count", n_out - n0, 256);
    check("sweep_span", last_out_cyc - mark_cyc, 255);
    check("sweep_err_count", err_count, 8'd0);
    check("sweep_sticky", err_sticky, 1'b0);

    // Stall: downstream blocked while a stream is offered.
    out_ready = 1'b0;
    n0 = n_acc;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send_beat(32'hA0B0_C0D0 + 32'(k * 32'h0101_0101), 1'b0, 4'd0, 12'h000);
      end
      begin
        repeat (3) @(negedge clk);
        held = out_data;
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_c2_in_ready", c2_in_ready, 1'b0);
        check("stall_accepted", n_acc - n0, 2);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_data_stable", out_data, held);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_total", n_acc - n0, 6);

    // Injection on lane 2, then a clean beat.
    send_beat(32'h0102_0304, 1'b1, 4'd2, 12'h801);
    send_beat(32'h0506_0708, 1'b0, 4'd0, 12'h000);
    drain();
    check("inj_sticky", err_sticky, 1'b1);
    check("inj_count", err_count, 8'd1);

    // Ignored injections: lane out of range, and inj_en with no beat accepted.
    send_beat(32'h1122_3344, 1'b1, 4'd5, 12'h001);
    inj_en = 1'b1; inj_lane = 4'd0; inj_mask = 12'h001;
    idle(1);
    inj_en = 1'b0;
    send_beat(32'h5566_7788, 1'b0, 4'd0, 12'h000);
    drain();
    check("ignored_inj_count", err_count, 8'd1);

    // Saturation on the 2-bit counter, then clear coinciding with an error.
    pulse_clr();
    check("clr_count", err_count, 8'd0);
    check("clr_sticky", err_sticky, 1'b0);
    send_beat(32'h0000_0010, 1'b1, 4'd0, 12'h001);
    send_beat(32'h0000_2000, 1'b1, 4'd1, 12'h010);
    send_beat(32'h0030_0000, 1'b1, 4'd2, 12'h300);
    send_beat(32'h4000_0000, 1'b1, 4'd3, 12'h808);
    send_beat(32'h0000_0050, 1'b1, 4'd0, 12'h100);
    drain();
    check("sat_c2_count", c2_err_count, 2'd3);
    check("sat_main_count", err_count, 8'd5);
    check("sat_c2_sticky", c2_err_sticky, 1'b1);
    out_ready = 1'b0;
    send_beat(32'h1122_3344, 1'b1, 4'd3, 12'h004);
    for (int t = 0; t < 20 && !out_valid; t++) idle(1);
    check("clr_race_valid", out_valid, 1'b1);
    err_clr = 1'b1;
    out_ready = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("clr_race_count", err_count, 8'd0);
    check("clr_race_c2_count", c2_err_count, 2'd0);
    check("clr_race_sticky", err_sticky, 1'b0);
    check("clr_race_c2_sticky", c2_err_sticky, 1'b0);
    check("clr_race_drained", exp_q.size(), 0);

    // Reset with two beats in flight.
    send_beat(32'hDEAD_BEEF, 1'b1, 4'd1, 12'h002);
    drain();
    check("pre_rst_count", err_count, 8'd1);
    out_ready = 1'b0;
    send_beat(32'h0F0F_0F0F, 1'b0, 4'd0, 12'h000);
    send_beat(32'hF0F0_F0F0, 1'b1, 4'd0, 12'h001);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_c2_out_valid", c2_out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_count", err_count, 8'd0);
    check("mid_rst_sticky", err_sticky, 1'b0);
    check("mid_rst_out_err", out_err, 4'h0);
    n0 = n_out;
    out_ready = 1'b1;
    idle(5);
    check("mid_rst_no_output", n_out - n0, 0);
    send_beat(32'h0123_4567, 1'b0, 4'd0, 12'h000);
    drain();
    check("post_rst_count", err_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
